// File: rtl/dmem_resp.sv
// dmem_resp: MEM-stage data memory responder with WAIT_CYCLES wait states.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_resp #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_regwrite,
    input  logic [3:0]  req_destreg,
    input  logic [15:0] req_result,
    output logic        stall,
    output logic        wb_regwrite,
    output logic [3:0]  wb_destreg,
    output logic [15:0] wb_data,
    output logic        err
);

    localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
`ifdef DMEM_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          wb_regwrite_q;
    logic [3:0]    wb_destreg_q;
    logic [15:0]   wb_data_q;
    logic          err_q;
    logic [15:0]   mem_q [DEPTH];

    logic          req;
    logic          access;
    logic          oor;
    logic          wr_en;
    logic [AW-1:0] idx;
    logic [15:0]   rdata;
    logic [15:0]   wb_data_d;

    // Decode request, completion point and the addressed word
    always_comb begin
        req    = req_read | req_write;
        idx    = req_addr[AW-1:0];
        oor    = RANGE_EN & (|(req_addr >> AW));
        stall  = 1'b0;
        access = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                stall  = req && (WC != 4'd0);
                access = req && (WC == 4'd0);
            end else begin
                stall  = (cnt_q > 4'd1);
                access = (cnt_q == 4'd1);
            end
        end
        wr_en     = access & req_write & ~oor;
        rdata     = oor ? 16'hFFFF : mem_q[idx];
        wb_data_d = (access & req_read) ? rdata : req_result;
    end

    // Request FSM with wait counter and registered MEM/WB outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            wb_regwrite_q <= 1'b0;
            wb_destreg_q  <= 4'd0;
            wb_data_q     <= 16'd0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!req) begin
                        wb_regwrite_q <= req_regwrite;
                        wb_destreg_q  <= req_destreg;
                        wb_data_q     <= req_result;
                    end else if (WC == 4'd0) begin
                        err_q <= err_q | oor;
                        if (req_write) begin
                            wb_regwrite_q <= 1'b0;
                        end else begin
                            wb_regwrite_q <= req_regwrite;
                            wb_destreg_q  <= req_destreg;
                            wb_data_q     <= wb_data_d;
                        end
                    end else begin
                        state_q       <= BUSY;
                        cnt_q         <= WC;
                        wb_regwrite_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q > 4'd1) begin
                        cnt_q         <= cnt_q - 4'd1;
                        wb_regwrite_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        err_q   <= err_q | oor;
                        if (req_write) begin
                            wb_regwrite_q <= 1'b0;
                        end else begin
                            wb_regwrite_q <= req_regwrite;
                            wb_destreg_q  <= req_destreg;
                            wb_data_q     <= wb_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data array write port; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= req_wdata;
        end
    end

    assign wb_regwrite = wb_regwrite_q;
    assign wb_destreg  = wb_destreg_q;
    assign wb_data     = wb_data_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp (WAIT_CYCLES=3, DEPTH=256).
// Range-check expectations follow DMEM_RANGE_CHECK_EN.
module tb_dmem_resp;

    localparam int W = 3;
`ifdef DMEM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_regwrite = 1'b0;
    logic [3:0]  req_destreg = '0;
    logic [15:0] req_result = '0;
    logic        stall;
    logic        wb_regwrite;
    logic [3:0]  wb_destreg;
    logic [15:0] wb_data;
    logic        err;

    dmem_resp #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_regwrite(req_regwrite), .req_destreg(req_destreg),
        .req_result(req_result),
        .stall(stall), .wb_regwrite(wb_regwrite),
        .wb_destreg(wb_destreg), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: stall, 1: {regwrite,destreg,data}, 2: regwrite only, 3: err
    typedef struct {
        int          at;
        int          kind;
        logic [20:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(int at, int kind, logic [20:0] e, string nm);
        exp_t x;
        x.at = at; x.kind = kind; x.exp = e; x.name = nm;
        q.push_back(x);
    endfunction

    // Monitor: pop every expectation due this cycle and compare
    exp_t        m;
    logic [20:0] act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            m = q.pop_front();
            case (m.kind)
                0:       act = {20'b0, stall};
                1:       act = {wb_regwrite, wb_destreg, wb_data};
                2:       act = {wb_regwrite, 20'b0};
                default: act = {20'b0, err};
            endcase
            checks++;
            if (m.at != cyc || act !== m.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d: got %h, expected %h",
                         m.name, cyc, m.at, act, m.exp);
            end
        end
    end

    // Protocol check: request fields must hold while stalled
    logic [54:0] bun, bun_prev = '0;
    logic        st_prev = 1'b0;
    assign bun = {req_read, req_write, req_addr, req_wdata,
                  req_regwrite, req_destreg, req_result};
    always @(posedge clk) begin
        if (!reset && st_prev)
            assert (bun == bun_prev)
            else $error("protocol: request changed while stalled");
        st_prev  <= stall;
        bun_prev <= bun;
    end

    task automatic issue(input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic rw, input logic [3:0] dr,
                         input logic [15:0] res, input logic [15:0] rdexp,
                         input string nm);
        int n;
        n = (rd || wr) ? W + 1 : 1;
        req_read = rd; req_write = wr; req_addr = a; req_wdata = wd;
        req_regwrite = rw; req_destreg = dr; req_result = res;
        for (int i = 0; i < n; i++) begin
            push(cyc, 0, {20'b0, (i < n - 1)}, {nm, "_stall"});
            if (i < n - 1 || wr)
                push(cyc + 1, 2, 21'h0, {nm, "_nowb"});
            else
                push(cyc + 1, 1, {rw, dr, (rd ? rdexp : res)}, {nm, "_wb"});
            @(posedge clk);
            #1;
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        push(cyc, 0, 21'h0, {nm, "_stall"});
        push(cyc, 1, 21'h0, {nm, "_wb"});
        push(cyc, 3, 21'h0, {nm, "_err"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(0, 0, 16'h0000, 16'h0000, 1, 4'd3, 16'h1234, 16'h0, "pass");

        issue(0, 1, 16'h0010, 16'hBEEF, 1, 4'd7, 16'h0, 16'h0, "st10");
        issue(1, 0, 16'h0010, 16'h0000, 1, 4'd5, 16'h0, 16'hBEEF, "ld10");

        issue(0, 1, 16'h0030, 16'h1111, 0, 4'd0, 16'h0, 16'h0, "st30");
        issue(0, 1, 16'h0031, 16'h2222, 0, 4'd0, 16'h0, 16'h0, "st31");
        issue(1, 0, 16'h0030, 16'h0000, 1, 4'd1, 16'h0, 16'h1111, "b2b_ld30");
        issue(1, 0, 16'h0031, 16'h0000, 1, 4'd2, 16'h0, 16'h2222, "b2b_ld31");
        issue(0, 1, 16'h0030, 16'h3333, 1, 4'd4, 16'h0, 16'h0, "b2b_st30");
        issue(1, 0, 16'h0030, 16'h0000, 1, 4'd6, 16'h0, 16'h3333, "ld30b");

        issue(0, 1, 16'h0020, 16'h0000, 0, 4'd0, 16'h0, 16'h0, "st20z");
        req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
        req_regwrite = 1'b0; req_destreg = 4'd0;
        push(cyc, 0, 21'h1, "rb_stall0");
        push(cyc + 1, 2, 21'h0, "rb_bub0");
        @(posedge clk);
        #1;
        push(cyc, 0, 21'h1, "rb_stall1");
        push(cyc + 1, 2, 21'h0, "rb_bub1");
        @(posedge clk);
        #2;
        reset = 1'b1;
        chk_reset_vals("rb_in");
        @(posedge clk);
        #1;
        chk_reset_vals("rb_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_write = 1'b0;
        chk_reset_vals("rb_rel");
        @(posedge clk);
        #1;
        issue(1, 0, 16'h0020, 16'h0000, 1, 4'd8, 16'h0, 16'h0000, "ld20");

        issue(0, 1, 16'h0005, 16'h0ABC, 0, 4'd0, 16'h0, 16'h0, "st05");
        issue(0, 1, 16'h0105, 16'hCAFE, 0, 4'd0, 16'h0, 16'h0, "st105");
        issue(1, 0, 16'h0105, 16'h0000, 1, 4'd9, 16'h0,
              RC ? 16'hFFFF : 16'hCAFE, "ld105");
        issue(1, 0, 16'h0005, 16'h0000, 1, 4'd10, 16'h0,
              RC ? 16'h0ABC : 16'hCAFE, "ld05");
        push(cyc, 3, {20'b0, RC}, "err_flag");

        issue(1, 1, 16'h0001, 16'h00AA, 1, 4'd11, 16'h0, 16'h0, "rw01");
        issue(1, 0, 16'h0001, 16'h0000, 1, 4'd12, 16'h0, 16'h00AA, "ld01");

        issue(0, 0, 16'h0000, 16'h0000, 0, 4'd9, 16'h5A5A, 16'h0, "pass2");
        push(cyc, 3, {20'b0, RC}, "err_sticky");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
